uart_byte_tx: RTL and testbench
===============================

// Module: uart_byte_tx
// PURPOSE
//  Serialises one byte onto uart_tx as an 8N1 frame (start, D0..D7 LSB first,
//  optional parity, stop). Mirror of the UART byte receiver: same baud_set
//  encoding and 50 MHz system clock.
//  Sits between the RAM/readback logic and the board TX pin. One byte per Send_en.
// PARAMETERS
//  CLK_FREQ_HZ  50_000_000  system clock; divisor = CLK_FREQ_HZ/baud - 1
//  PARITY       0           0 none, 1 odd, 2 even (parity bit after D7)
//  STOP_BITS    1           1 or 2 stop bits
// PORTS
//  Clk       in   1  system clock
//  Reset_n   in   1  asynchronous, active-low reset
//  Data      in   8  byte to send, sampled on accepted Send_en
//  Send_en   in   1  single-cycle request; accepted only when Tx_busy==0
//  baud_set  in   3  0:9600 1:19200 2:38400 3:57600 4:115200; 5..7 -> 9600
//  uart_tx   out  1  serial line, idle high
//  Tx_Done   out  1  one-cycle pulse when the last stop bit completes
//  Tx_busy   out  1  high from accepted Send_en to end of last stop bit
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame): uart_tx=1, Tx_Done=0, Tx_busy=0,
//    state IDLE, counters 0. Line returns high immediately; no partial frame resumes.
//  - Divisor BPS_DR (13 bit): 9600->5207, 19200->2603, 38400->1301,
//    57600->867, 115200->433. Each bit lasts BPS_DR+1 Clk cycles.
//  - Accept: Send_en=1 and Tx_busy=0 at edge k -> Data and BPS_DR latched,
//    Tx_busy=1 and uart_tx=0 (start bit) from k+1. Changing Data/baud_set
//    mid-frame has no effect on the current frame.
//  - Send_en while Tx_busy=1: ignored, not queued.
//  - FSM: IDLE -> START -> DATA(bit_idx 0..7) -> [PARITY] -> STOP(1 or 2) -> IDLE.
//    Transition on div_cnt==BPS_DR; div_cnt cleared on every transition and in IDLE.
//  - Parity: odd = ~^Data_latched, even = ^Data_latched.
//  - End of frame: at edge where last stop bit div_cnt==BPS_DR: Tx_Done=1 for
//    one cycle, Tx_busy=0, uart_tx stays 1.
//  - Back-to-back: Send_en in the Tx_Done cycle is accepted (Tx_busy already 0);
//    next start bit begins the following cycle; no idle gap required.
//  - Frame length: (1+8+(PARITY!=0)+STOP_BITS)*(BPS_DR+1) cycles, accept to Tx_Done.
//  - uart_tx driven from a register (glitch-free pin output).
// STRUCTURE
//  - Shared package uart_pkg: baud_set codes, BPS_DR function of
//    (CLK_FREQ_HZ, baud_set), parity encoding constants; also used by receiver.
//  - Sub-module uart_baud_tick: loadable divisor counter, enable, 1-cycle tick
//    at div_cnt==BPS_DR. FSM, shift register, parity in top.
// TESTING
//  1 baud_set=4, Data=8'hA5, Send_en pulse -> uart_tx 0,1,0,1,0,0,1,0,1,1
//    each 434 cycles; Tx_Done at 4340 cycles after accept; Tx_busy high throughout.
//  2 baud_set=0, Data=8'h00 -> start+8 zeros = 9*5208 cycles low, stop high;
//    Tx_Done at 52080 cycles.
//  3 Send_en re-pulsed with Data=8'hFF mid-frame of 8'h3C -> ignored; line
//    carries 8'h3C only; exactly one Tx_Done.
//  4 Send_en with 8'h55 asserted in Tx_Done cycle of previous frame -> new start
//    bit the next cycle; no idle-high gap; two Tx_Done pulses 4340 apart (baud 4).
//  5 Reset_n low at bit D3 -> uart_tx=1, Tx_busy=0 same cycle; after release
//    line stays idle until next Send_en; no Tx_Done.
//  6 PARITY=2, STOP_BITS=2, Data=8'h07 -> parity bit 1, two stop bits;
//    frame 12*(BPS_DR+1) cycles; loopback into receiver returns 8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud_set codes, baud divisor helper, parity modes and tx states.
// Used by both the byte transmitter and the byte receiver.
package uart_pkg;

  localparam int BPS_W = 13;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_code_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Codes 5..7 fall back to 9600; each branch folds to a constant once the clock rate is bound.
  function automatic logic [BPS_W-1:0] bps_dr(input int clk_freq_hz, input logic [2:0] baud_set);
    logic [BPS_W-1:0] dr;
    case (baud_code_e'(baud_set))
      BAUD_19200:  dr = BPS_W'(clk_freq_hz / 19200 - 1);
      BAUD_38400:  dr = BPS_W'(clk_freq_hz / 38400 - 1);
      BAUD_57600:  dr = BPS_W'(clk_freq_hz / 57600 - 1);
      BAUD_115200: dr = BPS_W'(clk_freq_hz / 115200 - 1);
      default:     dr = BPS_W'(clk_freq_hz / 9600 - 1);
    endcase
    return dr;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: holds the divisor loaded at frame accept and pulses tick for one
// cycle when the running count reaches it; the count restarts on every tick.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             load,
  input  logic [BPS_W-1:0] load_dr,
  input  logic             en,
  output logic             tick
);

  logic [BPS_W-1:0] bps_dr_reg;
  logic [BPS_W-1:0] div_cnt_reg;

  assign tick = en && (div_cnt_reg == bps_dr_reg);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bps_dr_reg <= '0;
    end else if (load) begin
      bps_dr_reg <= load_dr;
    end
  end

  // A new frame (load) always starts its start bit from a zero count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_reg <= '0;
    end else if (!en || tick || load) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + BPS_W'(1);
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start, D0..D7 LSB first, optional parity, 1 or 2 stop bits.
// Tx_Done marks the final cycle of the last stop bit so a new byte can follow with no gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Data,
  input  logic       Send_en,
  input  logic [2:0] baud_set,
  output logic       uart_tx,
  output logic       Tx_Done,
  output logic       Tx_busy
);

  localparam logic LAST_STOP = (STOP_BITS == 2);

  tx_state_e        state_reg, state_next;
  logic [7:0]       data_reg, data_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic             stop_idx_reg, stop_idx_next;
  logic             tx_reg, tx_next;
  logic             tick;
  logic             tick_en;
  logic             accept;
  logic             frame_end;
  logic             parity_bit;
  logic [BPS_W-1:0] baud_dr;

  assign baud_dr    = bps_dr(CLK_FREQ_HZ, baud_set);
  assign tick_en    = (state_reg != S_IDLE);
  assign frame_end  = (state_reg == S_STOP) && (stop_idx_reg == LAST_STOP) && tick;
  assign Tx_Done    = frame_end;
  assign Tx_busy    = (state_reg != S_IDLE) && !frame_end;
  assign accept     = Send_en && !Tx_busy;
  assign parity_bit = (PARITY == PARITY_ODD) ? ~^data_reg : ^data_reg;
  assign uart_tx    = tx_reg;

  uart_baud_tick u_baud_tick (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .load    (accept),
    .load_dr (baud_dr),
    .en      (tick_en),
    .tick    (tick)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg    <= S_IDLE;
      data_reg     <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      tx_reg       <= tx_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    tx_next       = 1'b1;

    case (state_reg)
      S_START: begin
        if (tick) begin
          state_next   = S_DATA;
          bit_idx_next = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_idx_reg == 3'd7) begin
            if (PARITY != PARITY_NONE) begin
              state_next = S_PARITY;
            end else begin
              state_next    = S_STOP;
              stop_idx_next = 1'b0;
            end
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_next    = S_STOP;
          stop_idx_next = 1'b0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (frame_end) begin
            state_next = S_IDLE;
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Accept is only possible in IDLE or in the Tx_Done cycle, so it overrides the frame end.
    if (accept) begin
      state_next    = S_START;
      data_next     = Data;
      bit_idx_next  = '0;
      stop_idx_next = 1'b0;
    end

    // The pin register is loaded with the level of the state being entered.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = data_next[bit_idx_next];
      S_PARITY: tx_next = parity_bit;
      default:  tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: three instances (8N1 at 50 MHz, even parity with two stop
// bits and odd parity with one stop bit at 5 MHz) run in parallel against a frame-level model.
module tb_uart_byte_tx;

  localparam int CLKF  [3] = '{50_000_000, 5_000_000, 5_000_000};
  localparam int PAR   [3] = '{0, 2, 1};
  localparam int STOPS [3] = '{1, 2, 1};
  localparam int NO_ABORT = 1 << 30;

  typedef struct {
    int          acc;
    int          div;
    int          nbits;
    logic [11:0] bits;
    logic [7:0]  data;
    int          abort_t;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic       rst_n   [3];
  logic       send_en [3];
  logic [7:0] data    [3];
  logic [2:0] baud    [3];
  logic       uart_tx [3];
  logic       tx_done [3];
  logic       tx_busy [3];
  int         mon_active [3];
  int         idle_err   [3];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_byte_tx #(.CLK_FREQ_HZ(CLKF[0]), .PARITY(PAR[0]), .STOP_BITS(STOPS[0])) dut0 (
    .Clk(clk), .Reset_n(rst_n[0]), .Data(data[0]), .Send_en(send_en[0]), .baud_set(baud[0]),
    .uart_tx(uart_tx[0]), .Tx_Done(tx_done[0]), .Tx_busy(tx_busy[0]));
  uart_byte_tx #(.CLK_FREQ_HZ(CLKF[1]), .PARITY(PAR[1]), .STOP_BITS(STOPS[1])) dut1 (
    .Clk(clk), .Reset_n(rst_n[1]), .Data(data[1]), .Send_en(send_en[1]), .baud_set(baud[1]),
    .uart_tx(uart_tx[1]), .Tx_Done(tx_done[1]), .Tx_busy(tx_busy[1]));
  uart_byte_tx #(.CLK_FREQ_HZ(CLKF[2]), .PARITY(PAR[2]), .STOP_BITS(STOPS[2])) dut2 (
    .Clk(clk), .Reset_n(rst_n[2]), .Data(data[2]), .Send_en(send_en[2]), .baud_set(baud[2]),
    .uart_tx(uart_tx[2]), .Tx_Done(tx_done[2]), .Tx_busy(tx_busy[2]));

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void note_fail(input string msg);
    checks++;
    failures++;
    $display("FAIL %s", msg);
  endfunction

  function automatic int rate_of(input logic [2:0] code);
    case (code)
      3'd1:    return 19200;
      3'd2:    return 38400;
      3'd3:    return 57600;
      3'd4:    return 115200;
      default: return 9600;
    endcase
  endfunction

  // Expected line levels for one frame, bit by bit, plus its bit period.
  function automatic exp_t model(input int idx, input logic [7:0] d, input logic [2:0] code,
                                 input int acc, input int abort_t);
    exp_t e;
    int   n;
    int   ones;
    e.acc     = acc;
    e.div     = CLKF[idx] / rate_of(code) - 1;
    e.data    = d;
    e.abort_t = abort_t;
    e.bits    = '1;
    e.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) e.bits[1 + i] = d[i];
    n    = 9;
    ones = $countones(d);
    if (PAR[idx] == 1) begin
      e.bits[n] = (ones % 2 == 0);
      n++;
    end else if (PAR[idx] == 2) begin
      e.bits[n] = (ones % 2 == 1);
      n++;
    end
    e.nbits = n + STOPS[idx];
    return e;
  endfunction

  task automatic push_exp(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int idx, output exp_t e, output bit ok);
    ok = 1'b0;
    case (idx)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic wait_idle(input int idx);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_busy[idx] && n < 60000) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy[idx])
      note_fail($sformatf("dut%0d idle_timeout: Tx_busy still 1 after %0d cycles, required 0", idx, n));
  endtask

  task automatic send(input int idx, input logic [7:0] d, input logic [2:0] code,
                      input int abort_t, output int acc);
    wait_idle(idx);
    data[idx]    = d;
    baud[idx]    = code;
    send_en[idx] = 1'b1;
    acc          = cyc + 1;
    push_exp(idx, model(idx, d, code, acc, abort_t));
    $display("dut%0d send data=%02h baud_set=%0d accept_cycle=%0d", idx, d, code, acc);
    @(posedge clk);
    #1;
    send_en[idx] = 1'b0;
    data[idx]    = 8'($urandom);
    baud[idx]    = 3'($urandom);
  endtask

  task automatic poke(input int idx, input logic [7:0] d);
    @(negedge clk);
    if (tx_busy[idx]) begin
      data[idx]    = d;
      send_en[idx] = 1'b1;
      $display("dut%0d mid-frame request data=%02h at cycle %0d (expect ignored)", idx, d, cyc);
      @(posedge clk);
      #1;
      send_en[idx] = 1'b0;
    end
  endtask

  task automatic monitor(input int idx);
    exp_t       e;
    bit         ok;
    bit         prev_busy;
    bit         aborted;
    int         total, per, b, busy_bad, done_at, done_cnt;
    int         bitbad [12];
    logic [7:0] rx;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_busy[idx] && !prev_busy) begin
        mon_active[idx] = 1;
        pop_exp(idx, e, ok);
        if (!ok) begin
          note_fail($sformatf("dut%0d unexpected_frame: start at cycle %0d, required none", idx, cyc));
          for (int k = 0; k < 80000 && tx_busy[idx]; k++) @(negedge clk);
        end else begin
          check($sformatf("dut%0d start_cycle", idx), cyc, e.acc);
          per = e.div + 1;
          total = e.nbits * per;
          foreach (bitbad[k]) bitbad[k] = 0;
          busy_bad = 0;
          done_at  = -1;
          done_cnt = 0;
          rx       = '0;
          aborted  = 1'b0;
          for (int t = 0; t < total; t++) begin
            if (t > 0) @(negedge clk);
            if (t == e.abort_t) begin
              aborted = 1'b1;
              check($sformatf("dut%0d reset_line", idx), uart_tx[idx], 1);
              check($sformatf("dut%0d reset_busy", idx), tx_busy[idx], 0);
              check($sformatf("dut%0d reset_done", idx), tx_done[idx], 0);
              break;
            end
            b = t / per;
            if (uart_tx[idx] !== e.bits[b]) bitbad[b]++;
            if (b >= 1 && b <= 8 && (t % per) == per / 2) rx[b - 1] = uart_tx[idx];
            if (tx_busy[idx] !== (t != total - 1)) busy_bad++;
            if (tx_done[idx]) begin
              done_cnt++;
              if (done_at < 0) done_at = t;
            end
          end
          for (int k = 0; k < e.nbits; k++)
            check($sformatf("dut%0d bit%0d_bad_cycles", idx, k), bitbad[k], 0);
          check($sformatf("dut%0d busy_bad_cycles", idx), busy_bad, 0);
          if (aborted) begin
            check($sformatf("dut%0d aborted_done_pulses", idx), done_cnt, 0);
          end else begin
            check($sformatf("dut%0d rx_byte", idx), rx, e.data);
            check($sformatf("dut%0d done_offset", idx), done_at, total - 1);
            check($sformatf("dut%0d done_pulses", idx), done_cnt, 1);
          end
        end
        mon_active[idx] = 0;
        prev_busy = 1'b0;
      end else begin
        if (!tx_busy[idx] && (uart_tx[idx] !== 1'b1 || tx_done[idx] !== 1'b0)) idle_err[idx]++;
        prev_busy = tx_busy[idx];
      end
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_mon
    initial monitor(gi);
  end

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: reached cycle %0d without finishing", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i]      = 1'b0;
      send_en[i]    = 1'b0;
      data[i]       = '0;
      baud[i]       = '0;
      mon_active[i] = 0;
      idle_err[i]   = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d por_line", i), uart_tx[i], 1);
      check($sformatf("dut%0d por_busy", i), tx_busy[i], 0);
      check($sformatf("dut%0d por_done", i), tx_done[i], 0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    fork
      begin : seq0
        int a1, a2, a3, a4, a5, abort_t;
        send(0, 8'hA5, 3'd4, NO_ABORT, a1);
        send(0, 8'h00, 3'd0, NO_ABORT, a2);
        check("dut0 a5_to_00_accept_gap", a2 - a1, 4340);
        send(0, 8'h3C, 3'd4, NO_ABORT, a3);
        check("dut0 00_to_3c_accept_gap", a3 - a2, 52080);
        repeat (1500) @(negedge clk);
        poke(0, 8'hFF);
        send(0, 8'h55, 3'd4, NO_ABORT, a4);
        check("dut0 3c_to_55_accept_gap", a4 - a3, 4340);
        abort_t = 4 * 434 + 37;
        send(0, 8'($urandom), 3'd4, abort_t, a5);
        check("dut0 55_to_next_accept_gap", a5 - a4, 4340);
        while (cyc < a5 + abort_t) begin
          @(posedge clk);
          #1;
        end
        rst_n[0] = 1'b0;
        $display("dut0 reset asserted at cycle %0d (bit D3)", cyc);
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        repeat (800) @(negedge clk);
      end
      begin : seq1
        int a;
        send(1, 8'h07, 3'd4, NO_ABORT, a);
        for (int i = 0; i < 6; i++) begin
          if (i % 2 == 1) begin
            wait_idle(1);
            repeat ($urandom_range(1, 60)) @(negedge clk);
          end
          send(1, 8'($urandom), 3'($urandom_range(0, 7)), NO_ABORT, a);
        end
      end
      begin : seq2
        int a;
        for (int i = 0; i < 7; i++) begin
          if (i % 3 == 2) begin
            wait_idle(2);
            repeat ($urandom_range(1, 60)) @(negedge clk);
          end
          send(2, 8'($urandom), 3'($urandom_range(0, 7)), NO_ABORT, a);
          if (i == 2) begin
            repeat (200) @(negedge clk);
            poke(2, 8'($urandom));
          end
        end
      end
    join

    for (int n = 0; n < 20000 &&
         (q0.size() + q1.size() + q2.size() > 0 ||
          mon_active[0] + mon_active[1] + mon_active[2] > 0); n++)
      @(negedge clk);
    check("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    check("monitors_idle", mon_active[0] + mon_active[1] + mon_active[2], 0);
    for (int i = 0; i < 3; i++) check($sformatf("dut%0d idle_line_errors", i), idle_err[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
